// File: rtl/regfile_wb_pkg.sv
// Shared defaults and arbiter state encoding for the register-file writeback scheduler.
package regfile_wb_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    typedef enum logic {
        ARB_LAST_A = 1'b0,
        ARB_LAST_B = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Busy-bit scoreboard for registers awaiting a long-latency writeback.
// Priority per edge: flush, then B-clear, then sb_set (set always wins).
module wb_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] chk_raddr1,
    input  logic [ADDR_W-1:0] chk_raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_err
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;
    logic                set_live;
    logic                dup_set;

    assign set_live = sb_set && (sb_addr != '0);

    // A re-set is only an error if nothing frees the bit in the same cycle.
    assign dup_set = set_live && busy[sb_addr] && !flush
                     && !(clr && (clr_addr == sb_addr));

    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else if (clr) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (set_live) begin
            busy_nxt[sb_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= '0;
            sb_err <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (dup_set) begin
                sb_err <= 1'b1;
            end
        end
    end

    assign busy1 = (chk_raddr1 != '0) && busy[chk_raddr1];
    assign busy2 = (chk_raddr2 != '0) && busy[chk_raddr2];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Round-robin share of the register-file write port between ALU (A) and long-latency (B) results.
// Optional macro REGFILE_WB_BYPASS_EN adds forwarding of the in-flight write to decode.
//
// state       | meaning
// ARB_LAST_A  | A won the last grant; B wins the next tie
// ARB_LAST_B  | B won the last grant (reset); A wins the next tie
module regfile_wb_scheduler #(
    parameter int NUM_REGS = regfile_wb_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_wb_pkg::ADDR_W,
    parameter int DATA_W   = regfile_wb_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] chk_raddr1,
    input  logic [ADDR_W-1:0] chk_raddr2,
    output logic              busy1,
    output logic              busy2,
    output logic              sb_err,
    output logic              reg_wr,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata
`ifdef REGFILE_WB_BYPASS_EN
    ,
    output logic              byp_hit1,
    output logic              byp_hit2,
    output logic [DATA_W-1:0] byp_data
`endif
);

    import regfile_wb_pkg::*;

    arb_state_t state;
    arb_state_t state_nxt;
    logic       grant_a;
    logic       grant_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_LAST_B;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_a   = 1'b0;
        grant_b   = 1'b0;
        if (a_valid && b_valid) begin
            if (state == ARB_LAST_A) begin
                grant_b   = 1'b1;
                state_nxt = ARB_LAST_B;
            end else begin
                grant_a   = 1'b1;
                state_nxt = ARB_LAST_A;
            end
        end else if (a_valid) begin
            grant_a   = 1'b1;
            state_nxt = ARB_LAST_A;
        end else if (b_valid) begin
            grant_b   = 1'b1;
            state_nxt = ARB_LAST_B;
        end
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    // Writes to x0 are accepted but dropped, leaving waddr/wdata as they were.
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else if (grant_a && (a_addr != '0)) begin
            reg_wr <= 1'b1;
            waddr  <= a_addr;
            wdata  <= a_data;
        end else if (grant_b && (b_addr != '0)) begin
            reg_wr <= 1'b1;
            waddr  <= b_addr;
            wdata  <= b_data;
        end else begin
            reg_wr <= 1'b0;
        end
    end

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .clr        (grant_b),
        .clr_addr   (b_addr),
        .flush      (flush),
        .chk_raddr1 (chk_raddr1),
        .chk_raddr2 (chk_raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .sb_err     (sb_err)
    );

`ifdef REGFILE_WB_BYPASS_EN
    assign byp_hit1 = reg_wr && (waddr != '0) && (waddr == chk_raddr1);
    assign byp_hit2 = reg_wr && (waddr != '0) && (waddr == chk_raddr2);
    assign byp_data = wdata;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: expected writes are queued at grant and popped at reg_wr.
module tb_regfile_wb_scheduler;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, b_valid, sb_set, flush;
    logic [4:0]  a_addr, b_addr, sb_addr, chk_raddr1, chk_raddr2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, busy1, busy2, sb_err, reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
`ifdef REGFILE_WB_BYPASS_EN
    logic        byp_hit1, byp_hit2;
    logic [31:0] byp_data;
`endif

    int errors = 0;
    int checks = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .flush      (flush),
        .chk_raddr1 (chk_raddr1),
        .chk_raddr2 (chk_raddr2),
        .busy1      (busy1),
        .busy2      (busy2),
        .sb_err     (sb_err),
        .reg_wr     (reg_wr),
        .waddr      (waddr),
        .wdata      (wdata)
`ifdef REGFILE_WB_BYPASS_EN
        ,
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2),
        .byp_data   (byp_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // One handshake cycle: check readies, queue accepted non-x0 writes, then check the output stage.
    task automatic tick(input logic exp_a, input logic exp_b);
        wr_t e;
        #1;
        chk("a_ready", 32'(a_ready), 32'(exp_a));
        chk("b_ready", 32'(b_ready), 32'(exp_b));
        if (exp_a && a_addr != 5'd0) begin
            e.addr = a_addr;
            e.data = a_data;
            exp_q.push_back(e);
        end
        if (exp_b && b_addr != 5'd0) begin
            e.addr = b_addr;
            e.data = b_data;
            exp_q.push_back(e);
        end
        cycle();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("reg_wr", 32'(reg_wr), 32'd1);
            chk("waddr", 32'(waddr), 32'(e.addr));
            chk("wdata", wdata, e.data);
        end else begin
            chk("reg_wr_idle", 32'(reg_wr), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0; sb_set = 0; flush = 0;
        a_addr = 0; b_addr = 0; sb_addr = 0; a_data = 0; b_data = 0;
        chk_raddr1 = 5'd7; chk_raddr2 = 5'd9;
        cycle();
        cycle();
        chk("rst_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_sb_err", 32'(sb_err), 32'd0);
        reset = 1'b0;

        // Single A write, then idle: address/data must hold.
        a_valid = 1; a_addr = 5'd5; a_data = 32'h1234;
        tick(1, 0);
        a_valid = 0;
        tick(0, 0);
        chk("hold_waddr", 32'(waddr), 32'd5);
        chk("hold_wdata", wdata, 32'h1234);

        // B alone leaves the arbiter in LAST_B, so the ties go A,B,A,B.
        b_valid = 1; b_addr = 5'd10; b_data = 32'hAA;
        tick(0, 1);
        a_valid = 1; a_addr = 5'd3; a_data = 32'h33;
        b_addr = 5'd4; b_data = 32'h44;
        tick(1, 0);
        tick(0, 1);
        tick(1, 0);
        tick(0, 1);
        a_valid = 0; b_valid = 0;

        // Scoreboard set, A write leaves busy, B write clears.
        sb_set = 1; sb_addr = 5'd7; chk_raddr1 = 5'd7;
        #1;
        chk("busy1_before_set", 32'(busy1), 32'd0);
        cycle();
        sb_set = 0;
        chk("busy1_set7", 32'(busy1), 32'd1);
        a_valid = 1; a_addr = 5'd7; a_data = 32'h70;
        tick(1, 0);
        a_valid = 0;
        chk("busy1_after_a", 32'(busy1), 32'd1);
        b_valid = 1; b_addr = 5'd7; b_data = 32'h77;
        tick(0, 1);
        b_valid = 0;
        chk("busy1_after_b", 32'(busy1), 32'd0);

        // Set and B-clear together on 9: set wins; a second set raises sticky sb_err.
        sb_set = 1; sb_addr = 5'd9; chk_raddr2 = 5'd9;
        b_valid = 1; b_addr = 5'd9; b_data = 32'h99;
        tick(0, 1);
        sb_set = 0; b_valid = 0;
        chk("busy2_set_wins", 32'(busy2), 32'd1);
        chk("sb_err_clean", 32'(sb_err), 32'd0);
        sb_set = 1; sb_addr = 5'd9;
        cycle();
        sb_set = 0;
        chk("sb_err_dup", 32'(sb_err), 32'd1);
        chk("busy2_dup", 32'(busy2), 32'd1);
        cycle();
        cycle();
        chk("sb_err_sticky", 32'(sb_err), 32'd1);

        // x0: accepted but no write; busy for x0 stays 0.
        a_valid = 1; a_addr = 5'd0; a_data = 32'hFFFF_FFFF;
        tick(1, 0);
        a_valid = 0;
        sb_set = 1; sb_addr = 5'd0; chk_raddr1 = 5'd0;
        cycle();
        sb_set = 0;
        chk("busy_x0", 32'(busy1), 32'd0);

        // Flush with a same-cycle set: only the new set survives.
        sb_set = 1; sb_addr = 5'd2;
        cycle();
        sb_addr = 5'd6;
        cycle();
        sb_set = 0;
        chk_raddr1 = 5'd2; chk_raddr2 = 5'd6;
        #1;
        chk("busy_2", 32'(busy1), 32'd1);
        chk("busy_6", 32'(busy2), 32'd1);
        flush = 1; sb_set = 1; sb_addr = 5'd8;
        cycle();
        flush = 0; sb_set = 0;
        chk("flush_2", 32'(busy1), 32'd0);
        chk("flush_6", 32'(busy2), 32'd0);
        chk_raddr1 = 5'd8; chk_raddr2 = 5'd9;
        #1;
        chk("flush_set8", 32'(busy1), 32'd1);
        chk("flush_9", 32'(busy2), 32'd0);

        // Leave the arbiter in LAST_A, then reset mid-stream with both valid.
        a_valid = 1; a_addr = 5'd11; a_data = 32'hB1;
        tick(1, 0);
        b_valid = 1; b_addr = 5'd12; b_data = 32'hC2;
        a_addr = 5'd13; a_data = 32'hD3;
        reset = 1;
        cycle();
        chk("rst2_reg_wr", 32'(reg_wr), 32'd0);
        chk("rst2_busy8", 32'(busy1), 32'd0);
        chk("rst2_sb_err", 32'(sb_err), 32'd0);
        reset = 0;
        tick(1, 0);
        tick(0, 1);
        a_valid = 0; b_valid = 0;
        tick(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
